// File: rtl/block_pos_ctrl.sv
// rtl/block_pos_ctrl.sv - PS/2 arrow-key driven positioning of several on-screen blocks
// Decodes set-2 scan codes into held direction flags and steps the selected block once per frame.
module block_pos_ctrl #(
   parameter int NUM_BLOCKS = 4,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int BLK_W      = 32,
   parameter int BLK_H      = 32,
   parameter int STEP       = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              key,
   input  logic                    new_code,
   input  logic                    frame_tick,
   input  logic                    mode,
   output logic [10*NUM_BLOCKS-1:0] xpos,
   output logic [10*NUM_BLOCKS-1:0] ypos,
   output logic [2:0]              sel,
   output logic                    moving
);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   localparam logic [10:0] XMAX = 11'(H_RES - BLK_W);
   localparam logic [10:0] YMAX = 11'(V_RES - BLK_H);
   localparam logic [10:0] STP  = 11'(STEP);
   localparam logic [2:0]  LAST = 3'(NUM_BLOCKS - 1);

   // flag bit order: 0 up, 1 down, 2 left, 3 right
   state_t      state_q, state_d;
   logic [3:0]  flags_q, flags_d;
   logic [2:0]  sel_q, sel_d;
   logic        moving_q;
   logic        esc;
   logic [9:0]  x_q [NUM_BLOCKS];
   logic [9:0]  y_q [NUM_BLOCKS];
   logic [9:0]  x_d [NUM_BLOCKS];
   logic [9:0]  y_d [NUM_BLOCKS];

   function automatic logic [3:0] dir_mask(input logic [7:0] code);
      case (code)
         8'h75:   return 4'b0001;
         8'h72:   return 4'b0010;
         8'h6B:   return 4'b0100;
         8'h74:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [9:0] step_dec(input logic [9:0] p, input logic [10:0] maxv,
                                           input logic wrap);
      logic [10:0] p11;
      p11 = {1'b0, p};
      if (p11 < STP) return wrap ? maxv[9:0] : 10'd0;
      return 10'(p11 - STP);
   endfunction

   function automatic logic [9:0] step_inc(input logic [9:0] p, input logic [10:0] maxv,
                                           input logic wrap);
      logic [10:0] s;
      s = {1'b0, p} + STP;
      if (s > maxv) return wrap ? 10'd0 : maxv[9:0];
      return s[9:0];
   endfunction

   always_comb begin
      state_d = state_q;
      flags_d = flags_q;
      sel_d   = sel_q;
      esc     = 1'b0;
      if (new_code) begin
         case (state_q)
            IDLE: begin
               if (key == 8'hE0)      state_d = EXT;
               else if (key == 8'hF0) state_d = BRK;
               else if (key == 8'h0D) sel_d = (sel_q == LAST) ? 3'd0 : sel_q + 3'd1;
               else if (key == 8'h76) esc = 1'b1;
            end
            EXT: begin
               if (key == 8'hF0) begin
                  state_d = EXT_BRK;
               end else begin
                  flags_d = flags_q | dir_mask(key);
                  state_d = IDLE;
               end
            end
            BRK: state_d = IDLE;
            default: begin
               flags_d = flags_q & ~dir_mask(key);
               state_d = IDLE;
            end
         endcase
      end
      if (esc) flags_d = 4'b0000;
   end

   // Movement uses flags_q so a code completing alongside frame_tick waits for the next frame
   always_comb begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
         if (esc) begin
            x_d[i] = 10'(2 * BLK_W * i);
            y_d[i] = 10'd0;
         end else if (frame_tick && (3'(i) == sel_q)) begin
            if (flags_q[2] && !flags_q[3])      x_d[i] = step_dec(x_q[i], XMAX, mode);
            else if (flags_q[3] && !flags_q[2]) x_d[i] = step_inc(x_q[i], XMAX, mode);
            if (flags_q[0] && !flags_q[1])      y_d[i] = step_dec(y_q[i], YMAX, mode);
            else if (flags_q[1] && !flags_q[0]) y_d[i] = step_inc(y_q[i], YMAX, mode);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         flags_q  <= 4'b0000;
         sel_q    <= 3'd0;
         moving_q <= 1'b0;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            x_q[i] <= 10'(2 * BLK_W * i);
            y_q[i] <= 10'd0;
         end
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         sel_q    <= sel_d;
         moving_q <= |flags_d;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_pack
      assign xpos[10*g +: 10] = x_q[g];
      assign ypos[10*g +: 10] = y_q[g];
   end

   assign sel    = sel_q;
   assign moving = moving_q;

endmodule

// File: tb/tb_block_pos_ctrl.sv
// tb/tb_block_pos_ctrl.sv - directed table-driven bench for block_pos_ctrl
module tb_block_pos_ctrl;

   localparam int NB = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [7:0]      key = 8'h00;
   logic            new_code = 1'b0;
   logic            frame_tick = 1'b0;
   logic            mode = 1'b0;
   logic [10*NB-1:0] xpos, ypos;
   logic [2:0]      sel;
   logic            moving;

   int tests = 0;
   int fails = 0;

   block_pos_ctrl #(.NUM_BLOCKS(NB)) dut (
      .clk(clk), .rst(rst), .key(key), .new_code(new_code), .frame_tick(frame_tick),
      .mode(mode), .xpos(xpos), .ypos(ypos), .sel(sel), .moving(moving)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       nc;
      logic [7:0] k;
      logic       t;
      logic       md;
      logic [9:0] ex;
      logic [9:0] ey;
      logic [2:0] es;
      logic       em;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [9:0] xo(input int i);
      return xpos[10*i +: 10];
   endfunction

   function automatic logic [9:0] yo(input int i);
      return ypos[10*i +: 10];
   endfunction

   task automatic add(input logic nc, input logic [7:0] k, input logic t, input logic md,
                      input int ex, input int ey, input int es, input logic em);
      vec_t v;
      v.nc = nc; v.k = k; v.t = t; v.md = md;
      v.ex = 10'(ex); v.ey = 10'(ey); v.es = 3'(es); v.em = em;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive for one clock, return at the following falling edge
   task automatic cyc(input logic nc, input logic [7:0] k, input logic t);
      new_code = nc; key = k; frame_tick = t;
      @(posedge clk);
      @(negedge clk);
      new_code = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic send(input logic [7:0] k);
      cyc(1'b1, k, 1'b0);
   endtask

   task automatic tick();
      cyc(1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      // E0 74 then four frames, then release
      add(1, 8'hE0, 0, 0,   0, 0, 0, 0);
      add(1, 8'h74, 0, 0,   0, 0, 0, 1);
      add(0, 8'h00, 1, 0,   8, 0, 0, 1);
      add(0, 8'h00, 1, 0,  16, 0, 0, 1);
      add(0, 8'h00, 1, 0,  24, 0, 0, 1);
      add(0, 8'h00, 1, 0,  32, 0, 0, 1);
      add(1, 8'hE0, 0, 0,  32, 0, 0, 1);
      add(1, 8'hF0, 0, 0,  32, 0, 0, 1);
      add(1, 8'h74, 0, 0,  32, 0, 0, 0);
      add(0, 8'h00, 1, 0,  32, 0, 0, 0);
      add(1, 8'h76, 0, 0,   0, 0, 0, 0);
      // left at x=0: clamp then wrap
      add(1, 8'hE0, 0, 0,   0, 0, 0, 0);
      add(1, 8'h6B, 0, 0,   0, 0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 0, 0, 1);
      add(1, 8'hE0, 0, 0,   0, 0, 0, 1);
      add(1, 8'hF0, 0, 0,   0, 0, 0, 1);
      add(1, 8'h6B, 0, 0,   0, 0, 0, 0);
      add(1, 8'hE0, 0, 1,   0, 0, 0, 0);
      add(1, 8'h6B, 0, 1,   0, 0, 0, 1);
      add(1, 8'h6B, 0, 1,   0, 0, 0, 1);
      add(0, 8'h00, 1, 1, 608, 0, 0, 1);
      add(0, 8'h00, 1, 1, 600, 0, 0, 1);
      add(0, 8'h00, 1, 1, 592, 0, 0, 1);
      add(1, 8'hE0, 0, 1, 592, 0, 0, 1);
      add(1, 8'hF0, 0, 1, 592, 0, 0, 1);
      add(1, 8'h6B, 0, 1, 592, 0, 0, 0);
      add(1, 8'h76, 0, 0,   0, 0, 0, 0);
      // up and down together hold y
      add(1, 8'hE0, 0, 1,   0, 0, 0, 0);
      add(1, 8'h75, 0, 1,   0, 0, 0, 1);
      add(1, 8'hE0, 0, 1,   0, 0, 0, 1);
      add(1, 8'h72, 0, 1,   0, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 1, 0, 0, 0, 1);
      add(1, 8'h76, 0, 0,   0, 0, 0, 0);
      // break without E0 is not a direction release
      add(1, 8'hE0, 0, 0,   0, 0, 0, 0);
      add(1, 8'h72, 0, 0,   0, 0, 0, 1);
      add(1, 8'hF0, 0, 0,   0, 0, 0, 1);
      add(1, 8'h72, 0, 0,   0, 0, 0, 1);
      add(0, 8'h00, 1, 0,   0, 8, 0, 1);
      add(1, 8'h76, 0, 0,   0, 0, 0, 0);

      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NB; i++) begin
         chk($sformatf("reset_x%0d", i), int'(xo(i)), 64 * i);
         chk($sformatf("reset_y%0d", i), int'(yo(i)), 0);
      end
      chk("reset_sel", int'(sel), 0);
      chk("reset_moving", int'(moving), 0);

      foreach (tbl[n]) begin
         mode = tbl[n].md;
         cyc(tbl[n].nc, tbl[n].k, tbl[n].t);
         chk($sformatf("vec%0d", n), int'({xo(0), yo(0), sel, moving}),
             int'({tbl[n].ex, tbl[n].ey, tbl[n].es, tbl[n].em}));
      end
      mode = 1'b0;

      // Tab cycling and selected-only movement
      for (int i = 1; i <= 4; i++) begin
         send(8'h0D);
         chk($sformatf("tab_sel%0d", i), int'(sel), i % NB);
      end
      send(8'hE0); send(8'h72);
      tick(); tick();
      chk("sel_y0", int'(yo(0)), 16);
      chk("sel_x0", int'(xo(0)), 0);
      for (int i = 1; i < NB; i++) begin
         chk($sformatf("unsel_x%0d", i), int'(xo(i)), 64 * i);
         chk($sformatf("unsel_y%0d", i), int'(yo(i)), 0);
      end
      send(8'h76);

      // flags survive Tab; Esc homes everything from a displaced state
      send(8'hE0); send(8'h74);
      send(8'h0D);
      chk("tab_keeps_moving", int'(moving), 1);
      tick();
      chk("blk1_x", int'(xo(1)), 72);
      chk("blk0_x_idle", int'(xo(0)), 0);
      send(8'h76);
      for (int i = 0; i < NB; i++) chk($sformatf("esc_x%0d", i), int'(xo(i)), 64 * i);
      chk("esc_y0", int'(yo(0)), 0);
      chk("esc_moving", int'(moving), 0);
      chk("esc_sel", int'(sel), 1);

      // reset mid-sequence discards the pending E0
      send(8'hE0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_sel", int'(sel), 0);
      send(8'h74);
      chk("rst_e0_moving", int'(moving), 0);
      tick();
      chk("rst_e0_x", int'(xo(0)), 0);

      // code completing with frame_tick moves only on the next frame
      send(8'hE0);
      cyc(1'b1, 8'h74, 1'b1);
      chk("same_tick_x", int'(xo(0)), 0);
      chk("same_tick_moving", int'(moving), 1);
      tick();
      chk("next_tick_x", int'(xo(0)), 8);

      // clamp on the right edge in mode 0
      for (int i = 0; i < 80; i++) tick();
      chk("clamp_right_x", int'(xo(0)), 608);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/block_pos_ctrl.md
BLOCK_POS_CTRL -- requirements
Module: block_pos_ctrl

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4, number of independently positioned blocks (1..8).
REQ-002 SHALL have parameter H_RES, default 640, visible pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, visible lines per frame.
REQ-004 SHALL have parameter BLK_W, default 32, block width in pixels.
REQ-005 SHALL have parameter BLK_H, default 32, block height in pixels.
REQ-006 SHALL have parameter STEP, default 8, pixels moved per frame per held axis (1..BLK_W).
REQ-007 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port key  input  8  PS/2 set-2 scan code byte, valid when new_code=1.
REQ-010 SHALL have port new_code  input  1  one-cycle strobe qualifying key.
REQ-011 SHALL have port frame_tick  input  1  one-cycle pulse once per frame (vblank start).
REQ-012 SHALL have port mode  input  1  edge behaviour: 0 = clamp, 1 = wrap.
REQ-013 SHALL have port xpos  output  10*NUM_BLOCKS  packed block x positions, block i at bits [10i+9:10i].
REQ-014 SHALL have port ypos  output  10*NUM_BLOCKS  packed block y positions, same packing.
REQ-015 SHALL have port sel  output  3  index of the currently selected block.
REQ-016 SHALL have port moving  output  1  high when any direction flag is held.

Function
REQ-017 SHALL decode bytes with FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), advancing only on cycles with new_code=1.
REQ-018 SHALL transition IDLE->EXT on E0, IDLE->BRK on F0, EXT->EXT_BRK on F0; every other byte completes the code and returns to IDLE.
REQ-019 SHALL set direction flags on extended make codes 75 (up), 72 (down), 6B (left), 74 (right) and clear the matching flag on the extended break of the same code.
REQ-020 SHALL ignore typematic repeats (a make for a held flag leaves it set) and unrecognised codes (no state change other than FSM return to IDLE).
REQ-021 SHALL advance sel on non-extended make 0D (Tab), sel+1, wrapping NUM_BLOCKS-1 -> 0; direction flags are not cleared on selection change.
REQ-022 SHALL, on non-extended make 76 (Esc), return all blocks to home and clear all direction flags in the cycle after the strobe.
REQ-023 SHALL update only the selected block, once per frame_tick, using flags as registered before that cycle; a code arriving with frame_tick affects the next frame.
REQ-024 SHALL hold an axis unchanged when both opposite flags on it are set.
REQ-025 SHALL bound x to 0..XMAX=H_RES-BLK_W and y to 0..YMAX=V_RES-BLK_H.
REQ-026 SHALL, with mode=0, produce x-STEP saturated at 0 and x+STEP saturated at XMAX (likewise y).
REQ-027 SHALL, with mode=1, move to XMAX when x<STEP moving left and to 0 when x+STEP>XMAX moving right (likewise y).
REQ-028 SHALL compute with 11-bit intermediates so no step wraps through 10-bit overflow.
REQ-029 SHALL place block i home at x=2*BLK_W*i, y=0 (defaults 0,64,128,192).
REQ-030 SHALL drive moving as the registered OR of the four flags (one-cycle latency after the code completes).

Reset
REQ-031 SHALL, while rst=0 at a rising clk, set FSM to IDLE, all flags 0, sel=0, moving=0, all blocks home; a partial E0/F0 sequence in progress is discarded.

Verification
REQ-032 SHALL cover: reset, then E0 74, 4 frame_ticks -> block0 x=32, y=0, moving=1; then E0 F0 74 -> moving=0, x stays 32.
REQ-033 SHALL cover: mode=0, block0 at x=0, E0 6B held 3 frames -> x=0; mode=1 same stimulus -> x=608, 600, 592.
REQ-034 SHALL cover: 0D x4 -> sel=1,2,3,0; then E0 72 for 2 frames -> only block0 y=16, blocks 1-3 unchanged.
REQ-035 SHALL cover: E0 75 and E0 72 both held 5 frames -> y unchanged, moving=1.
REQ-036 SHALL cover: blocks displaced, 76 -> next cycle all at home, moving=0; rst=0 after E0 only -> following 74 treated as non-extended (no movement).
REQ-037 SHALL cover: new_code with E0 74 completion in the same cycle as frame_tick -> no move that frame, x+8 on the next tick.
